accumulate: RTL
===============

# accumulate

Per-lane accumulation stage directly upstream of the block-RAM write stage. It consumes groups of `GROUP_SIZE` signed lanes and sums `num_acc` consecutive groups per lane with saturation, for example partial convolution results across input-channel slices. Each completed sum goes into a 4-slot output FIFO. The FIFO drains to the write stage through a valid/avail handshake.

## Interface
- `GROUP_SIZE`, 4, lanes per group
- `DATA_WIDTH`, 8, bits per lane; signed two's complement on input and output
- `LOG_MAX_ACC`, 8, width of the accumulation count
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `configure`  in  1  load `num_acc`; restarts the block
- `num_acc`  in  LOG_MAX_ACC  number of input groups summed per output group; 0 disables the block
- `data_in`  in  GROUP_SIZE*DATA_WIDTH  input group; lane i is bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- `valid_in`  in  1  input group present; accepted in the same cycle
- `avail_out`  out  1  upstream may assert `valid_in` next cycle
- `data_out`  out  GROUP_SIZE*DATA_WIDTH  accumulated group (FIFO head)
- `valid_out`  out  1  `data_out` transferred this cycle
- `avail_in`  in  1  downstream can accept this cycle (write stage `avail_out`)
- `overflow`  out  1  sticky flag: an input or result was dropped

## Operation
- Datapath registers:
  - `num_acc_r`, count register `cnt_r`
  - `GROUP_SIZE` accumulators `acc_r[i]`, each DATA_WIDTH wide
  - `state_r` ∈ {IDLE, RUN}
- Reset clears all registers:
  - state IDLE, `cnt_r`=0, all `acc_r`=0, FIFO empty, `overflow`=0
  - outputs: `valid_out`=0, `data_out`=0, `avail_out`=1
- State transitions:
  - IDLE: `valid_in` is ignored (data dropped, no flag). `configure` with `num_acc`≠0 → RUN.
  - RUN: `configure` with `num_acc`≠0 → RUN. `configure` with `num_acc`=0 → IDLE.
  - Any `configure` also loads `num_acc_r`, clears `cnt_r` and all `acc_r`, and discards any partial sum. The FIFO is not flushed.
- Simultaneous `configure` and `valid_in`: `configure` wins and the input is discarded.
- RUN, `valid_in`=1 per lane:
  - `sum = sat(acc_r[i] + lane_i)`, computed in DATA_WIDTH+1 bits.
  - Saturation bounds: -2^(DATA_WIDTH-1) and 2^(DATA_WIDTH-1)-1.
- If `cnt_r` = `num_acc_r`-1:
  - `sum` is pushed into the FIFO.
  - `acc_r` and `cnt_r` are cleared.
  - `num_acc`=1 makes this a saturating pass-through.
- Otherwise `acc_r` ← `sum` and `cnt_r` ← `cnt_r`+1.
- FIFO push while full: the result is dropped and `overflow` is set. `overflow` is cleared only by reset or `configure`. The accumulator still clears.
- `avail_out` = FIFO holds ≤2 entries, i.e. at least 2 free slots. This covers one input in flight.
- `valid_out` = FIFO not empty AND `avail_in`. The FIFO pops on `valid_out`.
- `data_out` = FIFO head when not empty, 0 when empty.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

## Timing
- Result latency:
  - The final input is accepted on edge N.
  - `valid_out` may assert in the cycle following edge N, provided `avail_in`=1.
  - Input to output: 1 cycle.
- Throughput: 1 input group per cycle. Output: 1 group per `num_acc` inputs.
- `avail_out` is registered-derived (from FIFO occupancy). `valid_out` combinationally follows `avail_in`.
- `avail_out` deasserts one cycle after occupancy reaches 3. Upstream may still present one group in that cycle without loss.
- Asynchronous reset mid-operation:
  - Outputs return to their reset values immediately, with no clock edge.
  - Partial sums and FIFO contents are lost.
  - The block stays IDLE until the next `configure`.

## Configuration
- `ACCUMULATE_RELU_EN` defined:
  - Each lane of a completed sum is clamped to 0 if negative before the FIFO push.
  - Intermediate `acc_r` values are not clamped.
- Not defined: completed sums are pushed unmodified (negative values pass through).
- No other behaviour changes. Latency is identical in both builds.

## Test plan
All scenarios use `GROUP_SIZE`=4, `DATA_WIDTH`=8.
- Basic sum:
  - Configure `num_acc`=3, `avail_in`=1.
  - Send lanes {1,2,3,4}, {10,20,30,40}, {5,5,5,5} on consecutive cycles.
  - Expect one `valid_out` pulse with lanes {16,27,38,49}, exactly 1 cycle after the third input.
- Saturation and ReLU:
  - Configure `num_acc`=2. Send {100,-100,127,-1} then {100,-100,1,0}.
  - Without `ACCUMULATE_RELU_EN`: expect {127,-128,127,-1}.
  - With `ACCUMULATE_RELU_EN`: expect {127,0,127,0}.
- Back-pressure:
  - `num_acc`=1, `avail_in`=0, stream inputs while `avail_out`=1.
  - Expect `avail_out` to fall after 3 results, no `overflow`, and 4 stored results.
  - Raise `avail_in`: expect 4 `valid_out` cycles in input order.
- Overflow:
  - Same setup, but force `valid_in` for 6 cycles, ignoring `avail_out`.
  - Expect `overflow`=1 and only the first 4 results delivered.
- Mid-stream configure:
  - `num_acc`=4. After 2 inputs of {1,1,1,1}, configure `num_acc`=2 together with `valid_in`.
  - Then send {3,3,3,3} twice. Expect a single output {6,6,6,6}.
- Async reset:
  - Assert `rst` between edges while the FIFO holds 2 entries.
  - Expect `valid_out`=0, `data_out`=0, `avail_out`=1 immediately.
  - Expect inputs ignored until the next `configure`.

Source files
------------

// File: rtl/accumulate.sv
// Per-lane saturating accumulator over num_acc input groups, feeding a 4-entry result FIFO.
// Optional ACCUMULATE_RELU_EN clamps negative lanes of completed sums to zero before the push.
module accumulate #(
  parameter int GROUP_SIZE  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int LOG_MAX_ACC = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             configure,
  input  logic [LOG_MAX_ACC-1:0]           num_acc,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             avail_in,
  output logic                             overflow,
  output logic                             dbg_state
);

  // Handshakes: upstream may drive valid_in in a cycle only if avail_out was high in the
  // previous cycle; valid_in is consumed in the cycle it is high. Downstream transfers data_out
  // in every cycle where valid_out is high, which is exactly FIFO-not-empty AND avail_in.
  localparam int GW    = GROUP_SIZE * DATA_WIDTH;
  localparam int DEPTH = 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [LOG_MAX_ACC-1:0] num_acc_q, num_acc_d;
  logic [LOG_MAX_ACC-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  acc_q [GROUP_SIZE];
  logic [DATA_WIDTH-1:0]  acc_d [GROUP_SIZE];
  logic [GW-1:0]          mem_q [DEPTH];
  logic [GW-1:0]          mem_d [DEPTH];
  logic [1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [2:0]             occ_q, occ_d;
  logic                   ovf_q, ovf_d;

  logic [DATA_WIDTH:0]    wide [GROUP_SIZE];
  logic [DATA_WIDTH-1:0]  sum  [GROUP_SIZE];
  logic [GW-1:0]          result;
  logic                   accept, last, pop, push;

  // Sign-extended add, then saturate when the two top bits disagree.
  always_comb begin
    result = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      wide[i] = {acc_q[i][DATA_WIDTH-1], acc_q[i]}
              + {data_in[(i+1)*DATA_WIDTH-1], data_in[i*DATA_WIDTH +: DATA_WIDTH]};
      if (wide[i][DATA_WIDTH] != wide[i][DATA_WIDTH-1]) begin
        sum[i] = wide[i][DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        sum[i] = wide[i][DATA_WIDTH-1:0];
      end
`ifdef ACCUMULATE_RELU_EN
      result[i*DATA_WIDTH +: DATA_WIDTH] = sum[i][DATA_WIDTH-1] ? '0 : sum[i];
`else
      result[i*DATA_WIDTH +: DATA_WIDTH] = sum[i];
`endif
    end
  end

  always_comb begin
    pop    = (occ_q != 3'd0) && avail_in;
    accept = (state_q == RUN) && valid_in && !configure;
    last   = (cnt_q == num_acc_q - LOG_MAX_ACC'(1));
    // A full FIFO can still take a result when its head leaves in the same cycle.
    push   = accept && last && ((occ_q != 3'd4) || pop);

    state_d   = state_q;
    num_acc_d = num_acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    for (int i = 0; i < GROUP_SIZE; i++) acc_d[i] = acc_q[i];
    for (int j = 0; j < DEPTH; j++) mem_d[j] = mem_q[j];

    if (configure) begin
      state_d   = (num_acc != '0) ? RUN : IDLE;
      num_acc_d = num_acc;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      for (int i = 0; i < GROUP_SIZE; i++) acc_d[i] = '0;
    end else if (accept) begin
      if (last) begin
        cnt_d = '0;
        for (int i = 0; i < GROUP_SIZE; i++) acc_d[i] = '0;
        if (!push) ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + LOG_MAX_ACC'(1);
        for (int i = 0; i < GROUP_SIZE; i++) acc_d[i] = sum[i];
      end
    end

    if (push) begin
      mem_d[wr_q] = result;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
    occ_d = occ_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_acc_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
      for (int i = 0; i < GROUP_SIZE; i++) acc_q[i] <= '0;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      num_acc_q <= num_acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      occ_q     <= occ_d;
      for (int i = 0; i < GROUP_SIZE; i++) acc_q[i] <= acc_d[i];
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
    end
  end

  assign avail_out = (occ_q <= 3'd2);
  assign valid_out = pop;
  assign data_out  = (occ_q != 3'd0) ? mem_q[rd_q] : '0;
  assign overflow  = ovf_q;
  assign dbg_state = (state_q == RUN);

endmodule
